// File: rtl/interface_pkg.sv
// Shared AHB-Lite encodings and the burst next-address rule used by the
// instruction-cache fill path and its memory-side responder.
package interface_pkg;

  typedef enum logic [3:0] {
    SINGLE = 4'd0,
    INCR   = 4'd1,
    WRAP4  = 4'd2,
    INCR4  = 4'd3
  } BURST_TYPES;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } HTRANS_T;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [31:0] WRAP4_BOUNDARY_MASK = 32'hFFFF_FFF0;

  // WRAP4 stays inside its 16-byte window; every other burst steps by a word.
  function automatic logic [31:0] next_beat_addr(input logic [31:0] addr,
                                                 input logic [3:0]  burst);
    if (burst == WRAP4)
      return (addr & WRAP4_BOUNDARY_MASK) | ((addr + 32'd4) & 32'h0000_000C);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/ahb_burst_tracker.sv
// Follows the currently open burst so every SEQ beat can be checked against
// the address, burst type and beat count the opening NONSEQ implies.
module ahb_burst_tracker
  import interface_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        upd_i,
  input  logic [1:0]  htrans_i,
  input  logic [31:0] haddr_i,
  input  logic [3:0]  hburst_i,
  input  logic        err_i,
  output logic        seq_ok_o
);

  logic        open_q, open_d;
  logic [2:0]  beat_q, beat_d;
  logic [31:0] exp_q, exp_d;
  logic [3:0]  burst_q, burst_d;
  logic        fixed4;

  assign fixed4   = (burst_q == INCR4) || (burst_q == WRAP4);
  assign seq_ok_o = open_q && (haddr_i == exp_q) && (hburst_i == burst_q) &&
                    !(fixed4 && (beat_q >= 3'd4));

  always_comb begin
    open_d  = open_q;
    beat_d  = beat_q;
    exp_d   = exp_q;
    burst_d = burst_q;
    if (upd_i) begin
      if (htrans_i == IDLE) begin
        open_d = 1'b0;
      end else if (htrans_i[1]) begin
        if (err_i) begin
          open_d = 1'b0;
        end else if (htrans_i == NONSEQ) begin
          open_d  = (hburst_i != SINGLE);
          burst_d = hburst_i;
          beat_d  = 3'd1;
          exp_d   = next_beat_addr(haddr_i, hburst_i);
        end else begin
          beat_d = beat_q + 3'd1;
          exp_d  = next_beat_addr(haddr_i, burst_q);
          if (fixed4 && (beat_q == 3'd3))
            open_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      open_q <= 1'b0;
      beat_q <= 3'd0;
    end else begin
      open_q <= open_d;
      beat_q <= beat_d;
    end
  end

  // Address and type are only meaningful while open_q is set.
  always_ff @(posedge clk) begin
    exp_q   <= exp_d;
    burst_q <= burst_d;
  end

endmodule

// File: rtl/ahb_mem_responder.sv
// AHB-Lite word memory subordinate with programmable wait states and a
// protocol checker that answers illegal transfers with a two-cycle ERROR.
module ahb_mem_responder
  import interface_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          MEM_WORDS   = 256,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [3:0]  hburst,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic        hresp
);

  localparam int          IDX_W = $clog2(MEM_WORDS);
  localparam logic [31:0] SPAN  = 32'(4 * MEM_WORDS);
  localparam logic [2:0]  WS    = 3'(WAIT_STATES);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_ERR1 = 3'd3;
  localparam logic [2:0] S_ERR2 = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [2:0]       wcnt_q, wcnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             write_q, write_d;
  logic [31:0]      hold_q, hold_d;
  logic [31:0]      mem_q [MEM_WORDS];

  logic [32:0] offset;
  logic        accept, range_bad, size_bad, align_bad, seq_ok, err;
  logic        rd_phase, wr_commit;

  assign hready = (state_q != S_WAIT) && (state_q != S_ERR1);
  assign hresp  = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

  // The extra bit borrows when haddr lies below ADDR_BASE.
  assign offset    = {1'b0, haddr} - {1'b0, ADDR_BASE};
  assign range_bad = offset[32] || (offset[31:0] >= SPAN);
  assign size_bad  = (hsize != 3'b010);
  assign align_bad = (haddr[1:0] != 2'b00);
  assign accept    = hready && hsel && htrans[1];
  assign err       = size_bad || align_bad || range_bad || ((htrans == SEQ) && !seq_ok);

  assign rd_phase  = (state_q == S_DATA) && !write_q;
  assign wr_commit = (state_q == S_DATA) && write_q;
  assign hrdata    = rd_phase ? mem_q[idx_q] : hold_q;

  ahb_burst_tracker u_tracker (
    .clk      (clk),
    .rstn     (rstn),
    .upd_i    (hready && hsel),
    .htrans_i (htrans),
    .haddr_i  (haddr),
    .hburst_i (hburst),
    .err_i    (err),
    .seq_ok_o (seq_ok)
  );

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    hold_d  = hold_q;
    if (rd_phase)
      hold_d = mem_q[idx_q];
    case (state_q)
      S_WAIT: begin
        if (wcnt_q <= 3'd1) begin
          state_d = S_DATA;
          wcnt_d  = 3'd0;
        end else begin
          wcnt_d = wcnt_q - 3'd1;
        end
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        // hready is high here, so a new address phase may be taken.
        state_d = S_IDLE;
        if (accept) begin
          idx_d   = offset[IDX_W+1:2];
          write_d = hwrite;
          if (err) begin
            state_d = S_ERR1;
          end else if (WS == 3'd0) begin
            state_d = S_DATA;
          end else begin
            state_d = S_WAIT;
            wcnt_d  = WS;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      wcnt_q  <= 3'd0;
      hold_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      hold_q  <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    idx_q   <= idx_d;
    write_q <= write_d;
  end

  // A reset landing on the data edge drops the pending write.
  always_ff @(posedge clk) begin
    if (rstn && wr_commit)
      mem_q[idx_q] <= hwdata;
  end

endmodule

// File: doc/ahb_mem_responder.md
# ahb_mem_responder

AHB-Lite subordinate that answers the transfers issued by the instruction-cache bus initiator. It holds a word-addressed backing memory, inserts a programmable number of wait states, and checks every SEQ beat against the expected SINGLE/INCR/INCR4/WRAP4 address sequence. Illegal or out-of-range transfers receive the two-cycle ERROR response. It is the memory-side model and the protocol checker for cache fill bursts.

## Interface

- ADDR_BASE, 32'h0000_0000: first byte address decoded by this block.
- MEM_WORDS, 256: backing-store depth in 32-bit words; power of two.
- WAIT_STATES, 0: hready-low cycles inserted before each OKAY data phase; legal range 0..7.
- clk  in  1  rising-edge clock
- rstn  in  1  reset; synchronous, active-low
- hsel  in  1  subordinate select
- haddr  in  32  byte address
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- hwrite  in  1  1 = write
- hsize  in  3  only 3'b010 (word) is legal
- hburst  in  4  BURST_TYPES encoding: SINGLE, INCR, WRAP4, INCR4
- hwdata  in  32  write data, valid in the data phase
- hrdata  out  32  read data, valid when hready=1 in an OKAY read data phase
- hready  out  1  transfer-done / bus-ready
- hresp  out  1  0 = OKAY, 1 = ERROR

## Operation

- The address phase is accepted on a rising edge with hready=1, hsel=1, and htrans equal to NONSEQ or SEQ. The block registers haddr, hwrite, hburst, and the error decision.
- IDLE, BUSY, or hsel=0 with hready=1 is no transfer. The next cycle is zero-wait OKAY. BUSY leaves the burst tracker unchanged.
- Error conditions, evaluated at acceptance:
  - hsize != word
  - haddr[1:0] != 0
  - haddr outside ADDR_BASE .. ADDR_BASE + 4*MEM_WORDS - 1
  - SEQ with no burst open
  - SEQ whose haddr differs from the tracker's expected address
  - SEQ beyond beat 4 of INCR4/WRAP4
  - SEQ with hburst differing from the opening NONSEQ
- Burst tracker:
  - A NONSEQ opens a burst, except SINGLE, which leaves none open, and sets beat count = 1.
  - Expected next address for INCR/INCR4 is addr+4.
  - Expected next address for WRAP4 is (addr & 32'hFFFF_FFF0) | ((addr+4) & 32'hC).
  - INCR4/WRAP4 close after beat 4. INCR stays open until the next NONSEQ or IDLE.
  - An errored transfer closes the burst.
- FSM states and transitions:
  - IDLE to WAIT if an OKAY transfer is accepted and WAIT_STATES>0.
  - IDLE to DATA if an OKAY transfer is accepted and WAIT_STATES=0.
  - IDLE to ERR1 if an errored transfer is accepted.
  - WAIT drives hready=0 and counts down WAIT_STATES cycles, then goes to DATA.
  - DATA drives hready=1 and hresp=0. A read drives hrdata=mem[index]. A write stores hwdata to mem[index] on this edge. DATA may accept the next transfer, making transfers back-to-back.
  - ERR1 drives hready=0 and hresp=1, then goes to ERR2.
  - ERR2 drives hready=1 and hresp=1. No memory write occurs. ERR2 may accept the next transfer.
- Memory index is (haddr - ADDR_BASE) >> 2, truncated to log2(MEM_WORDS) bits.

## Timing

- Reset values: hready=1, hresp=0, hrdata=0, FSM=IDLE, burst closed, wait counter 0. Memory contents are not reset.
- Reset asserted mid-transfer abandons the transfer at the next edge. A pending write is not committed.
- Read latency is WAIT_STATES+1 cycles from the address-phase edge to the hready=1 data edge. An error takes exactly 2 cycles.
- hrdata holds its last value outside read data phases.
- A write in the data phase followed by a read of the same word in the next address phase returns the new data. The memory write completes before the next read data phase.
- An address phase is presented while the previous data phase has hready=0. Inputs are ignored until hready=1.

## Structure

- Shared package interface_pkg holds:
  - BURST_TYPES, extended with INCR and INCR4
  - the HTRANS_T enum
  - HRESP_OKAY/HRESP_ERROR
  - WRAP4_BOUNDARY_MASK = 32'hFFFF_FFF0
- Sub-module ahb_burst_tracker holds the open flag, beat count, and expected address, and reports seq_ok.
- The top level holds the FSM, wait counter, address decode, and memory array.

## Test plan

- Preload mem[4]=32'hDEAD_BEEF, WAIT_STATES=0. SINGLE read of 0x10 gives hready=1 and hrdata=32'hDEAD_BEEF on the next edge.
- WRAP4 read from 0x38 issues beats 0x38, 0x3C, 0x30, 0x34. All four beats return OKAY with the correct words, with no error.
- WRAP4 SEQ at 0x40 after NONSEQ 0x3C gives ERR1 (hready=0, hresp=1), then ERR2 (hready=1, hresp=1), and mem is unchanged.
- With WAIT_STATES=2, a write of 32'h1234_5678 to 0x20 followed by a read of 0x20 shows hready low for 2 cycles on each transfer. The read returns 32'h1234_5678.
- A halfword transfer (hsize=1) gives a two-cycle ERROR. A read of ADDR_BASE+4*MEM_WORDS also gives a two-cycle ERROR.
- INCR4 read with BUSY inserted between beats 2 and 3 returns OKAY for all four beats. A fifth SEQ gives ERROR. Asserting rstn=0 during a WAIT cycle gives hready=1 and hresp=0 on the next edge.
